mmcm_drp_ctrl: RTL



---
 rtl/crg_pkg.sv | 35 +++
 rtl/mmcm_div_calc.sv | 21 ++
 rtl/mmcm_drp_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/crg_pkg.sv
// rtl/crg_pkg.sv - shared constants, state type and DRP address helper for the MMCM reconfiguration sequencer
package crg_pkg;

  localparam logic [6:0]  ADDR_BASE [3] = '{7'h08, 7'h0A, 7'h0C};
  localparam logic [15:0] KEEP      [2] = '{16'hF000, 16'hF3FF};

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_DRP_TO   = 2'b10;
  localparam logic [1:0] ERR_LOCK_TO  = 2'b11;

  typedef enum logic [3:0] {
    S_INIT_RST,
    S_IDLE,
    S_RST_HOLD,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_RELEASE,
    S_LOCK_WAIT
  } state_e;

  // r selects ClkReg1 (0) or ClkReg2 (1) of the chosen output.
  function automatic logic [6:0] drp_addr_of(input logic [1:0] sel, input logic r);
    logic [6:0] base;
    case (sel)
      2'd1:    base = ADDR_BASE[1];
      2'd2:    base = ADDR_BASE[2];
      default: base = ADDR_BASE[0];
    endcase
    return base + {6'd0, r};
  endfunction

endpackage

// File: rtl/mmcm_div_calc.sv
// rtl/mmcm_div_calc.sv - divide value to MMCM ClkReg1/ClkReg2 field encoder
module mmcm_div_calc (
  input  logic [7:0]  divide_i,
  output logic [15:0] reg1_o,
  output logic [15:0] reg2_o
);

  logic       div_one;
  logic [5:0] hi;
  logic [5:0] lo;

  // Divide-by-1 is encoded as 1/1 with the no-count bit set in ClkReg2.
  always_comb begin
    div_one = (divide_i == 8'd1);
    hi      = div_one ? 6'd1 : divide_i[6:1];
    lo      = div_one ? 6'd1 : 6'(divide_i - {1'b0, divide_i[7:1]});
    reg1_o  = {4'h0, hi, lo};
    reg2_o  = {4'h0, div_one, divide_i[0], 10'h000};
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// rtl/mmcm_drp_ctrl.sv - MMCM reset owner and DRP read-modify-write sequencer for output divide changes
module mmcm_drp_ctrl #(
  parameter int RST_HOLD     = 4,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk_in0,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_sel,
  input  logic [7:0]  cfg_divide,
  output logic [6:0]  drp_addr,
  output logic        drp_en,
  output logic        drp_we,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        clk_ok
);
  import crg_pkg::*;

  localparam int MAX_LIM = (LOCK_TIMEOUT > DRP_TIMEOUT)
                         ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                         : ((DRP_TIMEOUT > RST_HOLD) ? DRP_TIMEOUT : RST_HOLD);
  localparam int CNT_W = $clog2(MAX_LIM) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       div_q, div_d;
  logic             r_q, r_d;
  logic             init_q, init_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             drp_en_q, drp_en_d;
  logic             drp_we_q, drp_we_d;
  logic [6:0]       drp_addr_q, drp_addr_d;
  logic [15:0]      drp_di_q, drp_di_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [15:0]      reg1_new, reg2_new, merged;
  logic             req_legal;

  mmcm_div_calc u_div_calc (
    .divide_i (div_q),
    .reg1_o   (reg1_new),
    .reg2_o   (reg2_new)
  );

  assign req_legal = (cfg_sel != 2'd3) && (cfg_divide != 8'd0) && (cfg_divide <= 8'd126);
  assign merged    = r_q ? ((drp_do & KEEP[1]) | reg2_new) : ((drp_do & KEEP[0]) | reg1_new);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    sel_d      = sel_q;
    div_d      = div_q;
    r_d        = r_q;
    init_d     = init_q;
    mmcm_rst_d = mmcm_rst_q;
    drp_en_d   = 1'b0;
    drp_we_d   = 1'b0;
    drp_addr_d = drp_addr_q;
    drp_di_d   = drp_di_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_INIT_RST: if (cnt_q == HOLD_LAST) begin
        state_d    = S_RELEASE;
        mmcm_rst_d = 1'b0;
      end
      S_IDLE: if (cfg_valid && ready_q) begin
        if (!req_legal) begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end else begin
          sel_d      = cfg_sel;
          div_d      = cfg_divide;
          r_d        = 1'b0;
          mmcm_rst_d = 1'b1;
          state_d    = S_RST_HOLD;
        end
      end
      S_RST_HOLD: if (cnt_q == HOLD_LAST) begin
        state_d    = S_RD;
        drp_en_d   = 1'b1;
        drp_addr_d = drp_addr_of(sel_q, r_q);
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (drp_rdy) begin
          state_d  = S_WR;
          drp_en_d = 1'b1;
          drp_we_d = 1'b1;
          drp_di_d = merged;
        end else if (cnt_q == DRP_LAST) begin
          state_d    = S_IDLE;
          mmcm_rst_d = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_DRP_TO;
        end
      end
      S_WR: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (drp_rdy) begin
          if (!r_q) begin
            r_d        = 1'b1;
            state_d    = S_RD;
            drp_en_d   = 1'b1;
            drp_addr_d = drp_addr_of(sel_q, 1'b1);
          end else begin
            state_d    = S_RELEASE;
            mmcm_rst_d = 1'b0;
          end
        end else if (cnt_q == DRP_LAST) begin
          state_d    = S_IDLE;
          mmcm_rst_d = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_DRP_TO;
        end
      end
      S_RELEASE: begin
        state_d    = S_LOCK_WAIT;
        mmcm_rst_d = 1'b0;
      end
      S_LOCK_WAIT: begin
        // The power-up lock is not a reconfiguration, so it never reports done.
        if (mmcm_locked) begin
          state_d = S_IDLE;
          done_d  = ~init_q;
          init_d  = 1'b0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          init_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_LOCK_TO;
        end
      end
      default: state_d = S_INIT_RST;
    endcase
    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      cnt_d = '0;
    end
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT_RST;
      cnt_q      <= '0;
      sel_q      <= 2'd0;
      div_q      <= 8'd0;
      r_q        <= 1'b0;
      init_q     <= 1'b1;
      mmcm_rst_q <= 1'b1;
      drp_en_q   <= 1'b0;
      drp_we_q   <= 1'b0;
      drp_addr_q <= 7'd0;
      drp_di_q   <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      r_q        <= r_d;
      init_q     <= init_d;
      mmcm_rst_q <= mmcm_rst_d;
      drp_en_q   <= drp_en_d;
      drp_we_q   <= drp_we_d;
      drp_addr_q <= drp_addr_d;
      drp_di_q   <= drp_di_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign drp_addr  = drp_addr_q;
  assign drp_en    = drp_en_q;
  assign drp_we    = drp_we_q;
  assign drp_di    = drp_di_q;
  assign mmcm_rst  = mmcm_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign clk_ok    = mmcm_locked & ~busy_q;

endmodule
